// File: rtl/fb_arbiter.sv
// rtl/fb_arbiter.sv - framebuffer access controller sharing one bitmap RAM between the UART writer and OLED reader
module fb_arbiter #(
  parameter int ROWS    = 80,
  parameter int TIMEOUT = 48000
) (
  input  logic        clk_48mhz,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_strobe,
  input  logic        rd_req,
  input  logic [7:0]  rd_row,
  output logic        rd_valid,
  output logic [15:0] rd_pixels,
  output logic [6:0]  mem_addr,
  output logic        mem_we,
  output logic [1:0]  mem_wmask,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        frame_done,
  output logic        overrun
);

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [7:0]    LAST_OFF = 8'(2 * ROWS - 1);
  localparam logic [7:0]    ROWS_B   = 8'(ROWS);
  localparam logic [CW-1:0] IDLE_MAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WR, RD, RD_DATA} state_t;

  state_t        state;
  logic          buf_valid;
  logic [7:0]    buf_data;
  logic [7:0]    buf_off;
  logic [7:0]    offset;
  logic [CW-1:0] idle_cnt;
  logic          last_rd;
  logic          rd_oob;

  logic commit, accept, wr_pend, rd_pend, grant_wr, grant_rd;

  // rd_req is still high in the rd_valid cycle; it must not start a second read.
  always_comb begin
    commit   = (state == WR);
    accept   = rx_strobe && (!buf_valid || commit);
    wr_pend  = buf_valid;
    rd_pend  = rd_req && !rd_valid;
    grant_wr = (state == IDLE) && wr_pend && (!rd_pend || last_rd);
    grant_rd = (state == IDLE) && rd_pend && (!wr_pend || !last_rd);
  end

  always_ff @(posedge clk_48mhz) begin
    if (!reset) begin
      state      <= IDLE;
      buf_valid  <= 1'b0;
      buf_data   <= 8'd0;
      buf_off    <= 8'd0;
      offset     <= 8'd0;
      idle_cnt   <= '0;
      last_rd    <= 1'b0;
      rd_oob     <= 1'b0;
      rd_valid   <= 1'b0;
      rd_pixels  <= 16'd0;
      mem_addr   <= 7'd0;
      mem_we     <= 1'b0;
      mem_wmask  <= 2'b00;
      mem_wdata  <= 16'd0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rd_valid   <= 1'b0;
      mem_we     <= 1'b0;
      frame_done <= 1'b0;

      if (commit)
        buf_valid <= 1'b0;
      if (accept) begin
        buf_valid <= 1'b1;
        buf_data  <= rx_data;
        buf_off   <= offset;
      end
      if (rx_strobe && !accept)
        overrun <= 1'b1;

      if (rx_strobe)
        idle_cnt <= '0;
      else if (idle_cnt != IDLE_MAX)
        idle_cnt <= idle_cnt + CW'(1);

      // Offset snaps to 0 on the cycle the idle counter reaches TIMEOUT.
      if (accept)
        offset <= (offset == LAST_OFF) ? 8'd0 : offset + 8'd1;
      else if (!rx_strobe && idle_cnt == IDLE_MAX - CW'(1))
        offset <= 8'd0;

      case (state)
        IDLE: begin
          if (grant_wr) begin
            state      <= WR;
            last_rd    <= 1'b0;
            mem_we     <= 1'b1;
            mem_addr   <= buf_off[7:1];
            mem_wmask  <= buf_off[0] ? 2'b01 : 2'b10;
            mem_wdata  <= {buf_data, buf_data};
            frame_done <= (buf_off == LAST_OFF);
          end else if (grant_rd) begin
            state   <= RD;
            last_rd <= 1'b1;
            rd_oob  <= (rd_row >= ROWS_B);
            if (rd_row < ROWS_B)
              mem_addr <= rd_row[6:0];
          end
        end
        WR:      state <= IDLE;
        RD:      state <= RD_DATA;
        RD_DATA: begin
          state     <= IDLE;
          rd_valid  <= 1'b1;
          rd_pixels <= rd_oob ? 16'd0 : mem_rdata;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_arbiter.sv
// tb/tb_fb_arbiter.sv - directed bench for fb_arbiter with a byte-masked synchronous RAM model
module tb_fb_arbiter;

  localparam int TO = 200;

  logic        clk_48mhz;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_strobe;
  logic        rd_req;
  logic [7:0]  rd_row;
  logic        rd_valid;
  logic [15:0] rd_pixels;
  logic [6:0]  mem_addr;
  logic        mem_we;
  logic [1:0]  mem_wmask;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        frame_done;
  logic        overrun;

  int total = 0;
  int bad   = 0;
  int fd_cnt = 0;
  int rv_cnt = 0;

  logic [15:0] ram [0:127];

  logic        w_we;
  logic [6:0]  w_addr;
  logic [1:0]  w_mask;
  logic [15:0] w_data;
  logic [15:0] px;
  logic [6:0]  a1;
  int          lat;
  int          snap;

  fb_arbiter #(.ROWS(80), .TIMEOUT(TO)) dut (
    .clk_48mhz  (clk_48mhz),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_strobe  (rx_strobe),
    .rd_req     (rd_req),
    .rd_row     (rd_row),
    .rd_valid   (rd_valid),
    .rd_pixels  (rd_pixels),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wmask  (mem_wmask),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  initial clk_48mhz = 1'b0;
  always #10 clk_48mhz = ~clk_48mhz;

  always @(posedge clk_48mhz) begin
    if (mem_we) begin
      if (mem_wmask[1]) ram[mem_addr][15:8] <= mem_wdata[15:8];
      if (mem_wmask[0]) ram[mem_addr][7:0]  <= mem_wdata[7:0];
    end
    mem_rdata <= ram[mem_addr];
    if (frame_done) fd_cnt <= fd_cnt + 1;
    if (rd_valid)   rv_cnt <= rv_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_48mhz);
    #1;
  endtask

  // Byte into an idle arbiter; captures the write port in its commit cycle.
  task automatic send(input logic [7:0] b);
    rx_data   = b;
    rx_strobe = 1'b1;
    step();
    rx_strobe = 1'b0;
    step();
    w_we   = mem_we;
    w_addr = mem_addr;
    w_mask = mem_wmask;
    w_data = mem_wdata;
  endtask

  task automatic read_row(input logic [7:0] row, output logic [15:0] pix,
                          output int l, output logic [6:0] addr1);
    int n;
    step();
    rd_row = row;
    rd_req = 1'b1;
    l      = -1;
    pix    = 16'hdead;
    addr1  = 7'd0;
    n      = 0;
    while (l < 0 && n < 20) begin
      n++;
      step();
      if (n == 1) addr1 = mem_addr;
      if (rd_valid) begin
        l   = n;
        pix = rd_pixels;
      end
    end
    rd_req = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    rx_data   = 8'd0;
    rx_strobe = 1'b0;
    rd_req    = 1'b0;
    rd_row    = 8'd0;
    repeat (3) step();
    check("reset_ctl", {rd_valid, mem_we, frame_done, overrun, mem_wmask, mem_addr}, 0);
    check("reset_pix", rd_pixels, 0);
    check("reset_wdata", mem_wdata, 0);
    reset = 1'b1;
    step();

    // Full frame, bytes 0x00..0x9F one per 32 cycles
    for (int i = 0; i < 160; i++) begin
      rx_data   = 8'(i);
      rx_strobe = 1'b1;
      step();
      rx_strobe = 1'b0;
      if (i == 0) check("wr_t1", mem_we, 0);
      step();
      if (i == 0) check("wr_t2", {mem_we, mem_wmask, mem_addr, mem_wdata}, {1'b1, 2'b10, 7'd0, 16'h0000});
      if (i == 159) check("last_wr", {mem_we, frame_done, mem_wmask, mem_addr}, {1'b1, 1'b1, 2'b01, 7'd79});
      repeat (30) step();
    end
    check("frame_done_cnt", fd_cnt, 1);

    read_row(8'd0, px, lat, a1);
    check("row0", px, 16'h0001);
    check("row0_lat", lat, 3);
    read_row(8'd79, px, lat, a1);
    check("row79", px, 16'h9E9F);
    read_row(8'd5, px, lat, a1);
    check("row5", px, 16'h0A0B);
    check("row5_addr", a1, 5);
    check("row5_lat", lat, 3);

    read_row(8'd200, px, lat, a1);
    check("oob_pix", px, 0);
    check("oob_lat", lat, 3);
    check("oob_addr_t1", a1, 5);
    check("oob_addr_end", mem_addr, 5);
    check("overrun_clear", overrun, 0);

    // Two strobes while a read holds the RAM: second byte is dropped
    step();
    rd_row = 8'd1;
    rd_req = 1'b1;
    step();
    rx_data = 8'h55; rx_strobe = 1'b1;
    step();
    rx_data = 8'h66;
    step();
    rx_strobe = 1'b0;
    rd_req    = 1'b0;
    check("ovr_rd", {rd_valid, rd_pixels}, {1'b1, 16'h0203});
    check("ovr_flag", overrun, 1);
    step();
    check("ovr_wr", {mem_we, mem_wmask, mem_addr, mem_wdata}, {1'b1, 2'b10, 7'd0, 16'h5555});
    step();
    send(8'h77);
    check("ovr_next", {w_we, w_mask, w_addr, w_data}, {1'b1, 2'b01, 7'd0, 16'h7777});
    send(8'h88);
    check("off2", {w_we, w_mask, w_addr}, {1'b1, 2'b10, 7'd1});

    // TIMEOUT-1 idle cycles keep the offset; TIMEOUT idle cycles clear it
    repeat (TO - 2) step();
    send(8'h99);
    check("to_minus1", {w_we, w_mask, w_addr}, {1'b1, 2'b01, 7'd1});
    repeat (TO - 1) step();
    send(8'hAA);
    check("to_exact", {w_we, w_mask, w_addr, w_data}, {1'b1, 2'b10, 7'd0, 16'hAAAA});
    read_row(8'd0, px, lat, a1);
    check("row0_b", px, 16'hAA77);
    check("row0_b_lat", lat, 3);
    read_row(8'd1, px, lat, a1);
    check("row1_b", px, 16'h8899);

    // Tie with last grant = write: read wins, byte held and written afterwards
    step();
    rx_data = 8'h11; rx_strobe = 1'b1;
    step();
    rx_strobe = 1'b0;
    step();
    check("tieA_w0", {mem_we, mem_wmask, mem_addr}, {1'b1, 2'b01, 7'd0});
    rx_data = 8'h12; rx_strobe = 1'b1;
    rd_row = 8'd2; rd_req = 1'b1;
    step();
    rx_strobe = 1'b0;
    check("tieA_idle", mem_we, 0);
    step();
    check("tieA_rd", {mem_we, mem_addr}, {1'b0, 7'd2});
    step();
    step();
    check("tieA_valid", {rd_valid, rd_pixels}, {1'b1, 16'h0405});
    rd_req = 1'b0;
    step();
    check("tieA_wr", {mem_we, mem_wmask, mem_addr, mem_wdata}, {1'b1, 2'b10, 7'd1, 16'h1212});

    // Tie with last grant = read: write wins, read follows
    step();
    rd_row = 8'd3; rd_req = 1'b1;
    step();
    step();
    step();
    check("tieB_valid0", {rd_valid, rd_pixels}, {1'b1, 16'h0607});
    rx_data = 8'h13; rx_strobe = 1'b1;
    rd_row = 8'd4;
    step();
    rx_strobe = 1'b0;
    check("tieB_idle", mem_we, 0);
    step();
    check("tieB_wr", {mem_we, mem_wmask, mem_addr, mem_wdata}, {1'b1, 2'b01, 7'd1, 16'h1313});
    step();
    step();
    check("tieB_rd", {mem_we, mem_addr}, {1'b0, 7'd4});
    step();
    step();
    check("tieB_valid1", {rd_valid, rd_pixels}, {1'b1, 16'h0809});
    rd_req = 1'b0;
    read_row(8'd0, px, lat, a1);
    check("row0_c", px, 16'hAA11);
    read_row(8'd1, px, lat, a1);
    check("row1_c", px, 16'h1213);
    check("frame_done_end", fd_cnt, 1);

    // Reset while in RD abandons the read
    step();
    rd_row = 8'd1; rd_req = 1'b1;
    step();
    snap   = rv_cnt;
    reset  = 1'b0;
    rd_req = 1'b0;
    step();
    check("rst_ctl", {rd_valid, mem_we, frame_done, overrun, mem_wmask, mem_addr}, 0);
    check("rst_pix", {rd_pixels, mem_wdata}, 0);
    step();
    step();
    check("rst_no_valid", rv_cnt - snap, 0);
    reset = 1'b1;
    read_row(8'd1, px, lat, a1);
    check("rst_reread", px, 16'h1213);
    check("rst_reread_lat", lat, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
